// File: rtl/clocksm_sched.sv
// Resync/hold scheduler that drives syncin and veto of the 2-phase clock state machine.
// Optional CLOCKSM_SCHED_STATS_EN adds a saturating veto_cnt of effective veto cycles.
module clocksm_sched #(
  parameter int N        = 4,
  parameter int LW       = 6,
  parameter int SYNC_LEN = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sync_req,
  input  logic [N-1:0]    req,
  input  logic [N*LW-1:0] holdlen,
  input  logic            sm_sync,
  input  logic            sm_phase,
  output logic            syncin,
  output logic            veto,
  output logic [N-1:0]    gnt,
  output logic            busy,
  output logic            done
`ifdef CLOCKSM_SCHED_STATS_EN
  , output logic [15:0]   veto_cnt
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_GRANT, S_HOLD} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  rr_q, rr_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           pend_q, pend_d;
  logic [3:0]     scnt_q, scnt_d;
  logic [LW-1:0]  hcnt_q, hcnt_d;
  logic           syncin_q, syncin_d;
  logic           veto_q, veto_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           pick_found;
  logic [IW-1:0]  pick_idx;
  logic [IW-1:0]  next_idx;
  logic [LW-1:0]  cur_len;
  logic           q;

  // The state machine only honours veto while phase is high and sync is low.
  assign q        = sm_phase & ~sm_sync;
  assign cur_len  = holdlen[idx_q*LW +: LW];
  assign next_idx = (idx_q == IW'(N-1)) ? '0 : idx_q + IW'(1);

  // Round-robin pick: first asserted request at or after the pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!pick_found && req[(int'(rr_q) + k) % N]) begin
        pick_found = 1'b1;
        pick_idx   = IW'((int'(rr_q) + k) % N);
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    rr_d     = rr_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    scnt_d   = scnt_q;
    hcnt_d   = hcnt_q;
    syncin_d = 1'b0;
    veto_d   = 1'b0;
    gnt_d    = '0;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d  = S_SYNC;
          pend_d   = 1'b0;
          scnt_d   = 4'(SYNC_LEN);
          syncin_d = 1'b1;
        end else if (pick_found) begin
          state_d         = S_GRANT;
          idx_d           = pick_idx;
          gnt_d[pick_idx] = 1'b1;
        end
      end
      S_SYNC: begin
        if (scnt_q == 4'd1) begin
          state_d = S_IDLE;
          scnt_d  = '0;
        end else begin
          scnt_d   = scnt_q - 4'd1;
          syncin_d = 1'b1;
        end
      end
      S_GRANT: begin
        hcnt_d = cur_len;
        if (cur_len == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          rr_d    = next_idx;
        end else begin
          state_d      = S_HOLD;
          veto_d       = 1'b1;
          gnt_d[idx_q] = 1'b1;
        end
      end
      S_HOLD: begin
        if (!req[idx_q]) begin
          state_d = S_IDLE;
          hcnt_d  = '0;
          rr_d    = next_idx;
        end else if (q && hcnt_q == LW'(1)) begin
          state_d = S_IDLE;
          hcnt_d  = '0;
          done_d  = 1'b1;
          rr_d    = next_idx;
        end else begin
          if (q) hcnt_d = hcnt_q - LW'(1);
          veto_d       = 1'b1;
          gnt_d[idx_q] = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Set after the IDLE clear so a request arriving on the service cycle is kept.
    if (sync_req) pend_d = 1'b1;
    busy_d = (state_d != S_IDLE) || pend_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      scnt_q   <= '0;
      hcnt_q   <= '0;
      syncin_q <= 1'b0;
      veto_q   <= 1'b0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      scnt_q   <= scnt_d;
      hcnt_q   <= hcnt_d;
      syncin_q <= syncin_d;
      veto_q   <= veto_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign syncin = syncin_q;
  assign veto   = veto_q;
  assign gnt    = gnt_q;
  assign busy   = busy_q;
  assign done   = done_q;

`ifdef CLOCKSM_SCHED_STATS_EN
  logic [15:0] veto_cnt_q, veto_cnt_d;

  always_comb begin
    veto_cnt_d = veto_cnt_q;
    if (veto_q && q && veto_cnt_q != 16'hFFFF) veto_cnt_d = veto_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) veto_cnt_q <= '0;
    else       veto_cnt_q <= veto_cnt_d;
  end

  assign veto_cnt = veto_cnt_q;
`endif

endmodule
